// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
//   Stall/flush sequencer for the 5-stage core. Every cycle it decides which
//   pipeline registers advance, hold or load a bubble. It handles load-use
//   stalls, taken-branch flushes, instruction/data memory waits, and the
//   discard of a stale fetch that is still in flight after a redirect. It also
//   keeps saturating stall/flush counters and a data-memory watchdog.
//
//   Handshake: the memories use a level protocol. A MEM-stage access
//   (mem_access=1) completes in the cycle dmem_ready=1. A fetch completes in
//   the cycle imem_ready=1. Until then, the stage that owns the access holds.
//
// Ports
//   CLK, RST_N          clock, synchronous active-low reset
//   id_rs1/id_rs2       source registers of the ID instruction (+ *_used)
//   id_store            ID instruction is a store
//   ex_rd, ex_memRead   destination / load flag of the EX instruction
//   ex_branch_taken     EX redirects the PC
//   mem_access          MEM instruction performs a load/store
//   dmem_ready          data memory completes the MEM access this cycle
//   imem_ready          instruction memory returns a fetch this cycle
//   pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
//   ex_mem_write        pipeline register controls (combinational)
//   stall_cnt           cycles with pc_write=0, saturating
//   flush_cnt           taken-branch flush events, saturating
//   mem_timeout         sticky data-memory watchdog flag
//   dbg_state           current sequencer state (RUN/DWAIT/IWAIT/DROP)
// -----------------------------------------------------------------------------
module hazard_controller #(
   parameter bit STORE_FWD = 1'b1,
   parameter int CNT_W     = 16,
   parameter int TIMEOUT   = 255
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic             id_store,
   input  logic [4:0]       ex_rd,
   input  logic             ex_memRead,
   input  logic             ex_branch_taken,
   input  logic             mem_access,
   input  logic             dmem_ready,
   input  logic             imem_ready,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_write,
   output logic             id_ex_flush,
   output logic             ex_mem_write,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             mem_timeout,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DWAIT = 2'd1,
      IWAIT = 2'd2,
      DROP  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [8:0]       TMO     = 9'(TIMEOUT);

   state_t     state, next_state;
   logic [7:0] wait_cnt;
   logic       dwait, loaduse, branch_evt;

   assign dwait = mem_access & ~dmem_ready;

   // A load feeding only the data operand of a store does not stall when the
   // store data can be forwarded from WB.
   assign loaduse = ex_memRead && (ex_rd != 5'd0) &&
                    (((ex_rd == id_rs1) && id_rs1_used) ||
                     ((ex_rd == id_rs2) && id_rs2_used && !(STORE_FWD && id_store)));

   // The branch rule fires only where the RUN rules are evaluated and no data
   // wait takes priority. In DROP the EX slot already holds a bubble.
   assign branch_evt = (state != DROP) && !dwait && ex_branch_taken;

   assign dbg_state = state;

   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_write  = 1'b1;
      id_ex_flush  = 1'b0;
      ex_mem_write = 1'b1;
      next_state   = state;
      if (state == DROP) begin
         // Hold the redirect target and discard whatever fetch returns.
         pc_write    = 1'b0;
         if_id_flush = 1'b1;
         if (dwait) begin
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
         end
         next_state = imem_ready ? RUN : DROP;
      end else if (dwait) begin
         // RUN/IWAIT entering a data wait, or DWAIT still waiting: freeze.
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
         next_state   = DWAIT;
      end else if (ex_branch_taken) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         next_state  = imem_ready ? RUN : DROP;
      end else if (loaduse) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_flush = 1'b1;
         next_state  = RUN;
      end else if (!imem_ready) begin
         pc_write    = 1'b0;
         if_id_flush = 1'b1;
         next_state  = IWAIT;
      end else begin
         next_state = RUN;
      end
      if (!RST_N) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_write  = 1'b0;
         id_ex_flush  = 1'b1;
         ex_mem_write = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state       <= RUN;
         stall_cnt   <= '0;
         flush_cnt   <= '0;
         wait_cnt    <= 8'd0;
         mem_timeout <= 1'b0;
      end else begin
         state <= next_state;
         if (!pc_write && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_ONE;
         if (branch_evt && (flush_cnt != '1))
            flush_cnt <= flush_cnt + CNT_ONE;
         // Watchdog counts cycles spent waiting in DWAIT; it only reports,
         // the pipeline keeps waiting.
         if ((state == DWAIT) && dwait) begin
            if (wait_cnt != 8'hFF)
               wait_cnt <= wait_cnt + 8'd1;
            if (({1'b0, wait_cnt} + 9'd1) >= TMO)
               mem_timeout <= 1'b1;
         end else begin
            wait_cnt <= 8'd0;
         end
      end
   end

endmodule
